// File: rtl/top_a1_q4_rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot and encoded grant.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
module top_a1_q4_rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [15:0] dbl;
    logic [7:0] rot;
    logic [2:0] off;
    logic [2:0] win;
    logic       any;
    logic       release_now;

    // The legal hold range only matters with the timeout, but a bad value
    // is rejected in every build so a later enable cannot surprise anyone.
    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
            $error("MAX_HOLD out of range 2..255");
        end
    endgenerate

    // Rotate requests so index ptr-1 lands on the top bit, then take the
    // highest set bit; after reset (ptr=0) this is a plain 8:3 encoder.
    always_comb begin
        dbl = {req, req};
        rot = dbl[ptr +: 8];
        off = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (rot[j]) off = 3'(j);
        end
    end

    assign win         = off + ptr;
    assign any         = |req;
    assign release_now = done | ~req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       timeout_q;

    assign timeout = timeout_q;

    // Arbitration FSM with hold counter and forced release on overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            cnt         <= 8'd0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        state       <= GRANT;
                        grant       <= 8'b1 << win;
                        grant_idx   <= win;
                        grant_valid <= 1'b1;
                        cnt         <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        ptr         <= grant_idx;
                        grant       <= 8'h00;
                        grant_idx   <= 3'd0;
                        grant_valid <= 1'b0;
                    end else if (cnt == 8'(MAX_HOLD - 1)) begin
                        state       <= IDLE;
                        ptr         <= grant_idx;
                        grant       <= 8'h00;
                        grant_idx   <= 3'd0;
                        grant_valid <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign timeout = 1'b0;

    // Arbitration FSM; a grant is held until done or the holder drops req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        state       <= GRANT;
                        grant       <= 8'b1 << win;
                        grant_idx   <= win;
                        grant_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        ptr         <= grant_idx;
                        grant       <= 8'h00;
                        grant_idx   <= 3'd0;
                        grant_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_top_a1_q4_rr_arbiter_8.sv
// Bench for the 8-way round-robin arbiter: reference model plus
// directed vectors with literal expectations.
module tb_top_a1_q4_rr_arbiter_8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_chk;
    int n_fail;

    top_a1_q4_rr_arbiter_8 #(.MAX_HOLD(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: busy flag, holder, last winner, cycles held.
    logic       m_busy;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;
    int         m_held;
    logic       m_to;

    function automatic logic [2:0] pick(logic [7:0] r, logic [2:0] p);
        logic [2:0] w;
        w = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            int i;
            i = (int'(p) + 8 - k) % 8;
            if (r[i]) w = 3'(i);
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_idx  <= 3'd0;
            m_ptr  <= 3'd0;
            m_held <= 0;
            m_to   <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_busy) begin
                if (req != 8'h00) begin
                    m_busy <= 1'b1;
                    m_idx  <= pick(req, m_ptr);
                    m_held <= 1;
                end
            end else if (done || !req[m_idx]) begin
                m_busy <= 1'b0;
                m_ptr  <= m_idx;
                m_idx  <= 3'd0;
`ifdef ARB_TIMEOUT_EN
            end else if (m_held >= HOLD) begin
                m_busy <= 1'b0;
                m_ptr  <= m_idx;
                m_idx  <= 3'd0;
                m_to   <= 1'b1;
`endif
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [12:0] got;
            logic [12:0] exp;
            got = {grant, grant_idx, grant_valid, timeout};
            exp = {(m_busy ? (8'h01 << m_idx) : 8'h00), m_idx, m_busy, m_to};
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL model t=%0t: got %h want %h", $time, got, exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev,
                       input logic et);
        n_chk++;
        if ({grant, grant_idx, grant_valid, timeout} !== {eg, ei, ev, et}) begin
            n_fail++;
            $display("FAIL %s: got g=%h i=%0d v=%b t=%b want g=%h i=%0d v=%b t=%b",
                     nm, grant, grant_idx, grant_valid, timeout,
                     eg, ei, ev, et);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        #7;
        chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        done   = 1'b0;

        // Basic grant and rotation.
        do_reset();
        req = 8'b1000_0101;
        cyc(1);
        chk("first_win7", 8'h80, 3'd7, 1'b1, 1'b0);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("dead_after7", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1);
        chk("rot_win2", 8'h04, 3'd2, 1'b1, 1'b0);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("dead_after2", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1);
        chk("rot_win0", 8'h01, 3'd0, 1'b1, 1'b0);

        // Holder drops its request, then full rotation.
        do_reset();
        req = 8'hFF;
        cyc(1);
        chk("all_win7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h7F;
        cyc(1);
        chk("drop_release", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1);
        chk("after_drop6", 8'h40, 3'd6, 1'b1, 1'b0);
        req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            int e;
            e = (13 - k) % 8;
            done = 1'b1;
            cyc(1);
            done = 1'b0;
            chk("rot_dead", 8'h00, 3'd0, 1'b0, 1'b0);
            cyc(1);
            chk("rot_seq", 8'h01 << e, 3'(e), 1'b1, 1'b0);
        end

        // Grant does not switch while other requests change.
        req = 8'h41;
        cyc(3);
        chk("no_switch", 8'h40, 3'd6, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        req = 8'h08;
        cyc(1);
        chk("pre_async3", 8'h08, 3'd3, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_clear", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h09;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1);
        chk("post_reset3", 8'h08, 3'd3, 1'b1, 1'b0);

        // done while idle is ignored; done with req drop is one release.
        do_reset();
        done = 1'b1;
        cyc(3);
        done = 1'b0;
        chk("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h10;
        cyc(1);
        chk("win4", 8'h10, 3'd4, 1'b1, 1'b0);
        req  = 8'h20;
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("dual_release", 8'h00, 3'd0, 1'b0, 1'b0);
        cyc(1);
        chk("after_dual5", 8'h20, 3'd5, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after HOLD cycles.
        do_reset();
        req = 8'h02;
        cyc(1);
        for (int i = 0; i < HOLD; i++) begin
            chk("to_hold", 8'h02, 3'd1, 1'b1, 1'b0);
            cyc(1);
        end
        chk("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        cyc(1);
        chk("to_regrant", 8'h02, 3'd1, 1'b1, 1'b0);
`else
        // Without the timeout a grant is held indefinitely.
        do_reset();
        req = 8'h02;
        cyc(20);
        chk("long_hold", 8'h02, 3'd1, 1'b1, 1'b0);
`endif

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
